// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache (one word per line) and its main-memory sequencer.
// Optional DCACHE_STATS_EN adds saturating hit/miss/writeback counters.
module dcache_responder #(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              we_cache,
    input  logic              cache_input_type,
    input  logic              set_valid,
    input  logic              set_dirty,
    input  logic              we_memory,
    input  logic              fill_req,
    output logic              cache_hit,
    output logic              cache_dirty,
    output logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              fill_done,
    output logic              proto_err,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W   = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    // Cache arrays: only valid/dirty are reset
    logic [TAG_W-1:0]     r_tag   [NUM_LINES];
    logic [DATA_W-1:0]    r_data  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_pend_fill;
    logic [ADDR_W-1:0]    r_fill_addr;
    logic [DATA_W-1:0]    r_fill_buf;
    logic                 r_busy;
    logic                 r_fill_done;
    logic                 r_proto_err;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_mem_we;
    logic                 r_mem_re;

    logic                 w_pend_fill_nxt;
    logic [ADDR_W-1:0]    w_fill_addr_nxt;
    logic [DATA_W-1:0]    w_fill_buf_nxt;
    logic                 w_fill_done_nxt;
    logic                 w_proto_err_nxt;
    logic [ADDR_W-1:0]    w_mem_addr_nxt;
    logic [DATA_W-1:0]    w_mem_wdata_nxt;
    logic                 w_mem_we_nxt;
    logic                 w_mem_re_nxt;

    logic [INDEX_W-1:0]   w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [ADDR_W-1:0]    w_word_addr;
    logic                 w_cmd;
    logic                 w_unused_addr_lsb;

    assign w_idx             = addr[INDEX_W+1:2];
    assign w_tag             = addr[ADDR_W-1:INDEX_W+2];
    assign w_word_addr       = {addr[ADDR_W-1:2], 2'b00};
    assign w_cmd             = we_memory | fill_req;
    assign w_unused_addr_lsb = ^addr[1:0];

    assign cache_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign cache_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign read_data   = r_data[w_idx];

    assign busy      = r_busy;
    assign fill_done = r_fill_done;
    assign proto_err = r_proto_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;

    // Line data/tag update; victim reads above see pre-write contents
    always_ff @(posedge clk) begin
        if (we_cache) begin
            r_data[w_idx] <= cache_input_type ? write_data : r_fill_buf;
            r_tag[w_idx]  <= w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (we_cache) begin
            r_valid[w_idx] <= set_valid;
            r_dirty[w_idx] <= set_dirty;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pend_fill <= 1'b0;
            r_fill_addr <= '0;
            r_fill_buf  <= '0;
            r_busy      <= 1'b0;
            r_fill_done <= 1'b0;
            r_proto_err <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_fill <= w_pend_fill_nxt;
            r_fill_addr <= w_fill_addr_nxt;
            r_fill_buf  <= w_fill_buf_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_fill_done <= w_fill_done_nxt;
            r_proto_err <= w_proto_err_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_re    <= w_mem_re_nxt;
        end
    end

    // Next state: writeback always precedes a same-cycle fill
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (we_memory)     w_state_nxt = S_WB;
                else if (fill_req) w_state_nxt = S_FILL;
            end
            S_WB: begin
                if (mem_ack) w_state_nxt = r_pend_fill ? S_FILL : S_IDLE;
            end
            S_FILL: begin
                if (mem_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        w_pend_fill_nxt = r_pend_fill;
        w_fill_addr_nxt = r_fill_addr;
        w_fill_buf_nxt  = r_fill_buf;
        w_fill_done_nxt = 1'b0;
        w_proto_err_nxt = r_proto_err | ((r_state != S_IDLE) & w_cmd);
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = r_mem_we;
        w_mem_re_nxt    = r_mem_re;
        case (r_state)
            S_IDLE: begin
                if (we_memory) begin
                    w_mem_addr_nxt  = {r_tag[w_idx], w_idx, 2'b00};
                    w_mem_wdata_nxt = r_data[w_idx];
                    w_mem_we_nxt    = 1'b1;
                    w_pend_fill_nxt = fill_req;
                    w_fill_addr_nxt = w_word_addr;
                end else if (fill_req) begin
                    w_mem_addr_nxt  = w_word_addr;
                    w_mem_re_nxt    = 1'b1;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    w_mem_we_nxt = 1'b0;
                    if (r_pend_fill) begin
                        w_mem_addr_nxt  = r_fill_addr;
                        w_mem_re_nxt    = 1'b1;
                        w_pend_fill_nxt = 1'b0;
                    end
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    w_fill_buf_nxt  = mem_rdata;
                    w_mem_re_nxt    = 1'b0;
                    w_fill_done_nxt = 1'b1;
                end
            end
            default: begin
                w_mem_we_nxt = 1'b0;
                w_mem_re_nxt = 1'b0;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;
    logic [31:0] r_stat_wbs;
    logic        w_hit_evt;
    logic        w_wb_evt;

    assign w_hit_evt   = (r_state == S_IDLE) & ~fill_req & we_cache & cache_input_type;
    assign w_wb_evt    = (r_state == S_IDLE) & we_memory;
    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
    assign stat_wbs    = r_stat_wbs;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
            r_stat_wbs    <= '0;
        end else begin
            if (w_hit_evt && (r_stat_hits != '1))     r_stat_hits   <= r_stat_hits + 32'(1);
            if (r_fill_done && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 32'(1);
            if (w_wb_evt && (r_stat_wbs != '1))       r_stat_wbs    <= r_stat_wbs + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: refill, store hit, writeback+fill, protocol error, mid-transaction reset.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        we_cache;
    logic        cache_input_type;
    logic        set_valid;
    logic        set_dirty;
    logic        we_memory;
    logic        fill_req;
    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] read_data;
    logic        busy;
    logic        fill_done;
    logic        proto_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    dcache_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .addr             (addr),
        .write_data       (write_data),
        .we_cache         (we_cache),
        .cache_input_type (cache_input_type),
        .set_valid        (set_valid),
        .set_dirty        (set_dirty),
        .we_memory        (we_memory),
        .fill_req         (fill_req),
        .cache_hit        (cache_hit),
        .cache_dirty      (cache_dirty),
        .read_data        (read_data),
        .busy             (busy),
        .fill_done        (fill_done),
        .proto_err        (proto_err),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_re           (mem_re),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic line_write(input logic [31:0] a, input logic typ, input logic [31:0] d,
                              input logic v, input logic dt);
        addr = a; cache_input_type = typ; write_data = d;
        set_valid = v; set_dirty = dt; we_cache = 1'b1;
        tick();
        we_cache = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; write_data = '0; we_cache = 1'b0;
        cache_input_type = 1'b0; set_valid = 1'b0; set_dirty = 1'b0;
        we_memory = 1'b0; fill_req = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        addr = 32'h40;
        #1;

        // 1: reset state
        chk("rst_hit",   32'(cache_hit),   32'd0);
        chk("rst_dirty", 32'(cache_dirty), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_we",    32'(mem_we),      32'd0);
        chk("rst_re",    32'(mem_re),      32'd0);
        chk("rst_perr",  32'(proto_err),   32'd0);
        chk("rst_maddr", mem_addr,         32'h0);

        // 2: refill at 0x40, ack on the 4th request cycle
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        chk("f1_maddr", mem_addr,     32'h40);
        chk("f1_busy",  32'(busy),    32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("f1_re_hold", 32'(mem_re), 32'd1);
            tick();
        end
        chk("f1_re_4th", 32'(mem_re), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("f1_done",    32'(fill_done), 32'd1);
        chk("f1_re_drop", 32'(mem_re),    32'd0);
        chk("f1_idle",    32'(busy),      32'd0);
        line_write(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("f1_done_pulse", 32'(fill_done), 32'd0);
        chk("f1_hit",   32'(cache_hit),   32'd1);
        chk("f1_rdata", read_data,        32'hDEADBEEF);
        chk("f1_clean", 32'(cache_dirty), 32'd0);

        // 3: store hit
        line_write(32'h40, 1'b1, 32'h12345678, 1'b1, 1'b1);
        chk("st_rdata", read_data,        32'h12345678);
        chk("st_dirty", 32'(cache_dirty), 32'd1);
        chk("st_hit",   32'(cache_hit),   32'd1);

        // 4: conflict miss at 0x80: writeback of 0x40 then refill of 0x80
        addr = 32'h80;
        #1;
        chk("c_miss",  32'(cache_hit),   32'd0);
        chk("c_dirty", 32'(cache_dirty), 32'd1);
        we_memory = 1'b1; fill_req = 1'b1;
        tick();
        we_memory = 1'b0; fill_req = 1'b0;
        chk("wb_we",    32'(mem_we), 32'd1);
        chk("wb_re",    32'(mem_re), 32'd0);
        chk("wb_maddr", mem_addr,    32'h40);
        chk("wb_wdata", mem_wdata,   32'h12345678);
        line_write(32'h80, 1'b1, 32'hAAAA5555, 1'b1, 1'b0);
        chk("wb_wdata_keep", mem_wdata,   32'h12345678);
        chk("wb_we_hold",    32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("pf_we",    32'(mem_we), 32'd0);
        chk("pf_re",    32'(mem_re), 32'd1);
        chk("pf_maddr", mem_addr,    32'h80);
        chk("pf_busy",  32'(busy),   32'd1);
        tick();
        chk("pf_re_hold", 32'(mem_re), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk("pf_done", 32'(fill_done), 32'd1);
        chk("pf_idle", 32'(busy),      32'd0);
        line_write(32'h80, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("pf_rdata", read_data,      32'hCAFEF00D);
        chk("pf_hit",   32'(cache_hit), 32'd1);
        chk("pf_perr",  32'(proto_err), 32'd0);

        // 5: command while busy is dropped and flagged
        addr = 32'h44; fill_req = 1'b1;
        tick();
        chk("pe_maddr0", mem_addr, 32'h44);
        addr = 32'h100;
        tick();
        fill_req = 1'b0;
        chk("pe_flag",  32'(proto_err), 32'd1);
        chk("pe_maddr", mem_addr,       32'h44);
        chk("pe_re",    32'(mem_re),    32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0;
        chk("pe_done",   32'(fill_done), 32'd1);
        chk("pe_idle",   32'(busy),      32'd0);
        chk("pe_sticky", 32'(proto_err), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ia_busy", 32'(busy),      32'd0);
        chk("ia_re",   32'(mem_re),    32'd0);
        chk("ia_we",   32'(mem_we),    32'd0);
        chk("ia_done", 32'(fill_done), 32'd0);

        // 6: reset during writeback abandons it
        addr = 32'h80; we_memory = 1'b1;
        tick();
        we_memory = 1'b0;
        chk("r6_we",    32'(mem_we), 32'd1);
        chk("r6_maddr", mem_addr,    32'h80);
        chk("r6_wdata", mem_wdata,   32'hCAFEF00D);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("r6_we_drop", 32'(mem_we),      32'd0);
        chk("r6_busy",    32'(busy),        32'd0);
        chk("r6_perr",    32'(proto_err),   32'd0);
        chk("r6_hit",     32'(cache_hit),   32'd0);
        chk("r6_dirty",   32'(cache_dirty), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("r6_late_busy", 32'(busy),      32'd0);
        chk("r6_late_re",   32'(mem_re),    32'd0);
        chk("r6_late_we",   32'(mem_we),    32'd0);
        chk("r6_late_done", 32'(fill_done), 32'd0);
        line_write(32'h80, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("r6_fillbuf", read_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
